// File: rtl/ppfifo_stream_writer.sv
// Producer-side adapter: valid/ready word stream into ping-pong FIFO buffers.
// Ports: clk/rst_n, i_stream_* (source), o_stream_ready, i_write_* / o_write_* (FIFO side), o_block_count, o_idle.
module ppfifo_stream_writer #(
    parameter int DATA_WIDTH    = 32,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_stream_valid,
    output logic                  o_stream_ready,
    input  logic [DATA_WIDTH-1:0] i_stream_data,
    input  logic                  i_stream_last,
    input  logic [1:0]            i_write_ready,
    output logic [1:0]            o_write_activate,
    input  logic [23:0]           i_write_fifo_size,
    output logic                  o_write_strobe,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic [23:0]           o_block_count,
    output logic                  o_idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RELEASE
    } state_t;

    localparam logic [23:0] TMO_LAST =
        (FLUSH_TIMEOUT > 0) ? 24'(FLUSH_TIMEOUT - 1) : 24'd0;

    state_t      state_q;
    state_t      state_d;
    logic        sel_q;
    logic        sel_d;
    logic        last_buf_q;
    logic [23:0] timer_q;
    logic        acquire;
    logic        xfer;
    logic        full_hit;
    logic        timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        acquire        = 1'b0;
        o_stream_ready = 1'b0;
        xfer           = 1'b0;
        full_hit       = 1'b0;
        timeout        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if ((i_write_ready != 2'b00) && (i_write_fifo_size != 24'd0)) begin
                    acquire = 1'b1;
                    state_d = S_FILL;
                    // Alternate when both are free, else take the only free one.
                    sel_d   = (&i_write_ready) ? ~last_buf_q : i_write_ready[1];
                end
            end
            S_FILL: begin
                o_stream_ready = (o_block_count < i_write_fifo_size);
                xfer           = i_stream_valid & o_stream_ready;
                full_hit       = ((o_block_count + 24'd1) == i_write_fifo_size);
                timeout        = (FLUSH_TIMEOUT != 0) && (o_block_count != 24'd0)
                                 && (timer_q == TMO_LAST);
                if (xfer && (full_hit || i_stream_last)) begin
                    state_d = S_RELEASE;
                end else if (!xfer && timeout) begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_write_activate <= 2'b00;
            o_write_strobe   <= 1'b0;
            o_write_data     <= '0;
            o_block_count    <= 24'd0;
            timer_q          <= 24'd0;
            sel_q            <= 1'b0;
            last_buf_q       <= 1'b1;
        end else begin
            o_write_strobe <= xfer;
            if (xfer) begin
                o_write_data  <= i_stream_data;
                o_block_count <= o_block_count + 24'd1;
                timer_q       <= 24'd0;
            end else if ((state_q == S_FILL) && (o_block_count != 24'd0)
                         && (timer_q != 24'hFF_FFFF)) begin
                timer_q <= timer_q + 24'd1;
            end
            if (acquire) begin
                o_write_activate <= sel_d ? 2'b10 : 2'b01;
                sel_q            <= sel_d;
                o_block_count    <= 24'd0;
                timer_q          <= 24'd0;
            end
            // Activate is held through RELEASE so the last strobe lands while owned.
            if (state_q == S_RELEASE) begin
                o_write_activate <= 2'b00;
                last_buf_q       <= sel_q;
            end
        end
    end

    assign o_idle = (state_q == S_IDLE) && (o_write_activate == 2'b00);

endmodule

// File: tb/tb_ppfifo_stream_writer.sv
// Directed bench for ppfifo_stream_writer: acquire, fill, last, timeout,
// buffer selection, async reset and a scoreboarded stream with ready gaps.
module tb_ppfifo_stream_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid;
    logic        sready;
    logic [31:0] sdata;
    logic        slast;
    logic [1:0]  wready;
    logic [1:0]  act;
    logic [23:0] size;
    logic        strobe;
    logic [31:0] wdata;
    logic [23:0] bcount;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ppfifo_stream_writer #(
        .DATA_WIDTH   (32),
        .FLUSH_TIMEOUT(16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_stream_valid   (valid),
        .o_stream_ready   (sready),
        .i_stream_data    (sdata),
        .i_stream_last    (slast),
        .i_write_ready    (wready),
        .o_write_activate (act),
        .i_write_fifo_size(size),
        .o_write_strobe   (strobe),
        .o_write_data     (wdata),
        .o_block_count    (bcount),
        .o_idle           (idle)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d, input logic l, input string tag);
        valid = 1'b1;
        sdata = d;
        slast = l;
        check({tag, "_rdy"}, 64'(sready), 64'd1);
        tick();
        check({tag, "_stb"}, 64'(strobe), 64'd1);
        check({tag, "_dat"}, 64'(wdata), 64'(d));
        valid = 1'b0;
        slast = 1'b0;
    endtask

    initial begin
        logic acc;
        rst_n  = 1'b0;
        valid  = 1'b0;
        sdata  = '0;
        slast  = 1'b0;
        wready = 2'b00;
        size   = 24'd4;
        #12;
        check("rst_act", 64'(act), 64'd0);
        check("rst_stb", 64'(strobe), 64'd0);
        check("rst_dat", 64'(wdata), 64'd0);
        check("rst_cnt", 64'(bcount), 64'd0);
        check("rst_rdy", 64'(sready), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        rst_n = 1'b1;

        // Both free, size 4: first pick is buffer 0, fills to full.
        wready = 2'b11;
        tick();
        check("acq0_act", 64'(act), 64'd1);
        check("acq0_idle", 64'(idle), 64'd0);
        push(32'hA0, 1'b0, "a0");
        push(32'hA1, 1'b0, "a1");
        push(32'hA2, 1'b0, "a2");
        push(32'hA3, 1'b0, "a3");
        check("full_rel_rdy", 64'(sready), 64'd0);
        check("full_rel_act", 64'(act), 64'd1);
        check("full_cnt", 64'(bcount), 64'd4);
        size = 24'd8;
        tick();
        check("full_drop_act", 64'(act), 64'd0);
        check("full_drop_stb", 64'(strobe), 64'd0);
        check("full_idle", 64'(idle), 64'd1);
        tick();
        check("acq1_act", 64'(act), 64'd2);

        // Size 8, last on third word.
        push(32'hB0, 1'b0, "b0");
        push(32'hB1, 1'b0, "b1");
        push(32'hB2, 1'b1, "b2");
        check("last_rel_rdy", 64'(sready), 64'd0);
        check("last_cnt", 64'(bcount), 64'd3);
        check("last_rel_act", 64'(act), 64'd2);
        wready = 2'b10;
        tick();
        check("last_drop_act", 64'(act), 64'd0);
        check("last_hold_cnt", 64'(bcount), 64'd3);

        // Only buffer 1 free after a buffer-1 release.
        tick();
        check("resel1_act", 64'(act), 64'd2);
        check("resel1_cnt", 64'(bcount), 64'd0);

        // Timeout: two words then idle.
        push(32'hC0, 1'b0, "c0");
        push(32'hC1, 1'b0, "c1");
        tick();
        check("tmo_stb0", 64'(strobe), 64'd0);
        for (int i = 2; i <= 16; i++) begin
            tick();
            check($sformatf("tmo_hold%0d", i), 64'(act), 64'd2);
        end
        check("tmo_rel_rdy", 64'(sready), 64'd0);
        wready = 2'b00;
        tick();
        check("tmo_drop_act", 64'(act), 64'd0);
        check("tmo_cnt", 64'(bcount), 64'd2);

        // Nothing free: stay idle.
        valid = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("none_act", 64'(act), 64'd0);
        check("none_rdy", 64'(sready), 64'd0);
        check("none_idle", 64'(idle), 64'd1);
        valid = 1'b0;

        // Empty buffer is never released by the timer.
        wready = 2'b01;
        tick();
        check("acq_only0", 64'(act), 64'd1);
        for (int i = 0; i < 24; i++) tick();
        check("empty_hold", 64'(act), 64'd1);

        // Asynchronous reset mid-stream.
        push(32'hD0, 1'b0, "d0");
        valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_act", 64'(act), 64'd0);
        check("arst_stb", 64'(strobe), 64'd0);
        check("arst_rdy", 64'(sready), 64'd0);
        check("arst_idle", 64'(idle), 64'd1);
        valid = 1'b0;
        tick();
        rst_n = 1'b1;

        // Stream with valid held and random free-flag gaps.
        size  = 24'd16;
        valid = 1'b1;
        sdata = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            wready = 2'($urandom_range(0, 3));
            acc    = sready & valid;
            if (acc) exp_q.push_back(sdata);
            tick();
            if (acc) sdata = sdata + 32'd1;
            if (act == 2'b11) check("both_act", 64'(act), 64'd0);
            if (strobe) begin
                if (exp_q.size() == 0) begin
                    check("sb_extra", 64'(wdata), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("sb_data", 64'(wdata), 64'(exp_q.pop_front()));
                end
            end
        end
        valid = 1'b0;
        tick();
        if (strobe && exp_q.size() != 0)
            check("sb_tail", 64'(wdata), 64'(exp_q.pop_front()));
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("sb_moved", 64'(sdata > 32'h1020), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
